// File: rtl/rgb_compositor.sv
// rtl/rgb_compositor.sv - prioritised layer compositor with frame-synchronised fade engine
// Two-stage pipeline: layer select, then per-channel brightness scaling by the fade level.
module rgb_compositor #(
    parameter int                    COLOR_BITS = 24,
    parameter int                    NUM_LAYERS = 4,
    parameter int                    FADE_LOG2  = 4,
    parameter logic [COLOR_BITS-1:0] BG_COLOR   = 24'hE0E0E0,
    parameter logic [COLOR_BITS-1:0] KEY_COLOR  = 24'h000000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             display_enable_i,
    input  logic [NUM_LAYERS-1:0]            layer_enable_i,
    input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_color_i,
    input  logic                             frame_tick_i,
    input  logic                             fade_out_req_i,
    input  logic                             fade_in_req_i,
    output logic [COLOR_BITS/3-1:0]          blue_o,
    output logic [COLOR_BITS/3-1:0]          green_o,
    output logic [COLOR_BITS/3-1:0]          red_o,
    output logic                             pixel_valid_o,
    output logic                             fade_busy_o,
    output logic                             fade_done_o
);

    localparam int CW = COLOR_BITS / 3;
    localparam int LW = FADE_LOG2 + 1;
    localparam logic [LW-1:0] MAX_LEVEL = {1'b1, {FADE_LOG2{1'b0}}};

    localparam logic [1:0] ST_VISIBLE    = 2'd0;
    localparam logic [1:0] ST_FADING_OUT = 2'd1;
    localparam logic [1:0] ST_BLACK      = 2'd2;
    localparam logic [1:0] ST_FADING_IN  = 2'd3;

    logic [COLOR_BITS-1:0] color1_d, color1_q;
    logic                  de1_d, de1_q;
    logic [CW-1:0]         red_d, red_q, green_d, green_q, blue_d, blue_q;
    logic                  valid_d, valid_q;
    logic [1:0]            state_d, state_q;
    logic [LW-1:0]         level_d, level_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;

    // Product is CW+LW bits wide so c * MAX never overflows; the shift drops the fraction.
    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [LW-1:0] lvl);
        logic [CW+LW-1:0] p;
        p = (CW+LW)'(c) * (CW+LW)'(lvl);
        return p[FADE_LOG2 +: CW];
    endfunction

    always_comb begin
        logic found;
        found    = 1'b0;
        color1_d = BG_COLOR;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!found && layer_enable_i[k] &&
                layer_color_i[k*COLOR_BITS +: COLOR_BITS] != KEY_COLOR) begin
                color1_d = layer_color_i[k*COLOR_BITS +: COLOR_BITS];
                found    = 1'b1;
            end
        end
        de1_d = display_enable_i;
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        valid_d = de1_q;
        if (de1_q) begin
            red_d   = scale(color1_q[0    +: CW], level_q);
            green_d = scale(color1_q[CW   +: CW], level_q);
            blue_d  = scale(color1_q[2*CW +: CW], level_q);
        end
    end

    // A request taken in a cycle suppresses the level step of a coincident tick.
    always_comb begin
        logic want_out, want_in;
        want_out = fade_out_req_i && !fade_in_req_i;
        want_in  = fade_in_req_i && !fade_out_req_i;
        state_d  = state_q;
        level_d  = level_q;
        done_d   = 1'b0;
        case (state_q)
            ST_VISIBLE: begin
                if (want_out) state_d = ST_FADING_OUT;
            end
            ST_BLACK: begin
                if (want_in) state_d = ST_FADING_IN;
            end
            ST_FADING_OUT: begin
                if (want_in) begin
                    state_d = ST_FADING_IN;
                end else if (frame_tick_i) begin
                    if (level_q <= LW'(1)) begin
                        level_d = '0;
                        state_d = ST_BLACK;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - LW'(1);
                    end
                end
            end
            default: begin
                if (want_out) begin
                    state_d = ST_FADING_OUT;
                end else if (frame_tick_i) begin
                    if (level_q >= MAX_LEVEL - LW'(1)) begin
                        level_d = MAX_LEVEL;
                        state_d = ST_VISIBLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q + LW'(1);
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_FADING_OUT) || (state_d == ST_FADING_IN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            color1_q <= '0;
            de1_q    <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            valid_q  <= 1'b0;
            state_q  <= ST_VISIBLE;
            level_q  <= MAX_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            color1_q <= color1_d;
            de1_q    <= de1_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign pixel_valid_o = valid_q;
    assign fade_busy_o   = busy_q;
    assign fade_done_o   = done_q;

endmodule

// File: tb/tb_rgb_compositor.sv
// tb/tb_rgb_compositor.sv - scoreboard bench for rgb_compositor
// Driver runs a level/direction model and queues expected results; monitor pops and compares.
module tb_rgb_compositor;

    localparam int MAXL = 16;

    logic        clk = 1'b1;
    logic        rst_i = 1'b1;
    logic        display_enable_i = 1'b0;
    logic [3:0]  layer_enable_i = '0;
    logic [95:0] layer_color_i = '0;
    logic        frame_tick_i = 1'b0;
    logic        fade_out_req_i = 1'b0;
    logic        fade_in_req_i = 1'b0;
    logic [7:0]  blue_o, green_o, red_o;
    logic        pixel_valid_o, fade_busy_o, fade_done_o;

    always #5 clk = ~clk;

    rgb_compositor dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .display_enable_i (display_enable_i),
        .layer_enable_i   (layer_enable_i),
        .layer_color_i    (layer_color_i),
        .frame_tick_i     (frame_tick_i),
        .fade_out_req_i   (fade_out_req_i),
        .fade_in_req_i    (fade_in_req_i),
        .blue_o           (blue_o),
        .green_o          (green_o),
        .red_o            (red_o),
        .pixel_valid_o    (pixel_valid_o),
        .fade_busy_o      (fade_busy_o),
        .fade_done_o      (fade_done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] pix_q[$];
    logic [1:0]  stat_q[$];

    int          m_level = MAXL;
    int          m_dir   = 0;
    logic        pend_v  = 1'b0;
    logic [23:0] pend_c  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] compose(input logic [3:0] en, input logic [95:0] cols);
        for (int k = 0; k < 4; k++)
            if (en[k] && cols[k*24 +: 24] != 24'h000000) return cols[k*24 +: 24];
        return 24'hE0E0E0;
    endfunction

    function automatic logic [23:0] fade(input logic [23:0] c, input int lvl);
        int r, g, b;
        r = int'(c[7:0])   * lvl / MAXL;
        g = int'(c[15:8])  * lvl / MAXL;
        b = int'(c[23:16]) * lvl / MAXL;
        return {b[7:0], g[7:0], r[7:0]};
    endfunction

    task automatic step(input logic rst, input logic de, input logic [3:0] en,
                        input logic [95:0] cols, input logic tick,
                        input logic fo, input logic fi);
        int   want;
        logic took, comp;
        @(negedge clk);
        rst_i            = rst;
        display_enable_i = de;
        layer_enable_i   = en;
        layer_color_i    = cols;
        frame_tick_i     = tick;
        fade_out_req_i   = fo;
        fade_in_req_i    = fi;
        took = 1'b0;
        comp = 1'b0;
        want = 0;
        if (rst) begin
            m_level = MAXL;
            m_dir   = 0;
        end else begin
            if (fo != fi) begin
                want = fo ? -1 : 1;
                if ((m_dir == 0 && ((want < 0 && m_level == MAXL) || (want > 0 && m_level == 0)))
                    || m_dir == -want) begin
                    m_dir = want;
                    took  = 1'b1;
                end
            end
            if (!took && tick && m_dir != 0) begin
                m_level = m_level + m_dir;
                if (m_level < 0)    m_level = 0;
                if (m_level > MAXL) m_level = MAXL;
                if ((m_dir < 0 && m_level == 0) || (m_dir > 0 && m_level == MAXL)) begin
                    m_dir = 0;
                    comp  = 1'b1;
                end
            end
        end
        stat_q.push_back({m_dir != 0, comp});
        if (!rst && pend_v) pix_q.push_back(pend_c);
        pend_v = de && !rst;
        pend_c = fade(compose(en, cols), m_level);
    endtask

    task automatic px(input logic tick, input logic fo, input logic fi, input logic rst);
        step(rst, 1'b1, 4'b0001, {72'h0, 24'h804020}, tick, fo, fi);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            px(1'b1, 1'b0, 1'b0, 1'b0);
            px(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [95:0] rand_cols();
        logic [95:0] c;
        for (int k = 0; k < 4; k++)
            c[k*24 +: 24] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
        return c;
    endfunction

    initial begin : monitor
        logic [1:0]  s;
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("fade_busy", 32'(fade_busy_o), 32'(s[1]));
                check("fade_done", 32'(fade_done_o), 32'(s[0]));
                if (pixel_valid_o) begin
                    if (pix_q.size() == 0) begin
                        check("unexpected_pixel", 32'(pixel_valid_o), 32'd0);
                    end else begin
                        e = pix_q.pop_front();
                        check("pixel", {8'h0, blue_o, green_o, red_o}, {8'h0, e});
                    end
                end else begin
                    check("blank_pixel", {8'h0, blue_o, green_o, red_o}, 32'h0);
                end
            end
        end
    end

    initial begin : driver
        step(1'b1, 1'b0, 4'h0, 96'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 96'h0, 1'b0, 1'b0, 1'b0);
        // Priority: layer 0 keyed, layer 1 wins over layer 3.
        step(1'b0, 1'b1, 4'hF, {24'hFFFFFF, 24'h555555, 24'h102030, 24'h000000}, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h0, {24'hFFFFFF, 24'h555555, 24'h102030, 24'h111111}, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h1, {72'h0, 24'hFFFFFF}, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 1'b0, 1'b0);
        // Full fade out, then back in.
        px(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(16);
        px(1'b1, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(16);
        // Reversal mid-fade.
        px(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        px(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(6);
        // Simultaneous requests, then request coincident with a tick.
        px(1'b0, 1'b1, 1'b1, 1'b0);
        px(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(16);
        px(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(16);
        // Reset in the middle of a fade-out.
        px(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        px(1'b0, 1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0, 4'($urandom),
                 rand_cols(), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 96'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_compositor.md
Name: rgb_compositor

Overview:
- Parametrised, pipelined successor to the playfield colour mux. Composites NUM_LAYERS prioritised colour layers over a background colour.
- Adds a frame-synchronised fade-in/fade-out engine used for game-state transitions (menu, level done, game over).
- Sits between the layer renderers (map, tanks, bullets, text/menu) and the video output.

Parameters:
- COLOR_BITS, 24: total pixel width; CW = COLOR_BITS/3 bits per channel. Packing is {blue, green, red}.
- NUM_LAYERS, 4: number of input layers. Layer 0 has the highest priority.
- FADE_LOG2, 4: the fade has 2^FADE_LOG2 steps. Let MAX = 2^FADE_LOG2.
- BG_COLOR, 24'hE0E0E0: colour shown where no layer is opaque.
- KEY_COLOR, 24'h000000: colour treated as transparent.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active-high
- display_enable_i  in  1  active-video qualifier
- layer_enable_i  in  NUM_LAYERS  per-layer enable; bit k belongs to layer k
- layer_color_i  in  NUM_LAYERS*COLOR_BITS  layer k occupies bits [k*COLOR_BITS +: COLOR_BITS]
- frame_tick_i  in  1  one-cycle pulse at start of frame
- fade_out_req_i  in  1  request fade to black (pulse)
- fade_in_req_i  in  1  request fade to full brightness (pulse)
- blue_o / green_o / red_o  out  CW each  composited, faded colour (registered)
- pixel_valid_o  out  1  display_enable_i delayed by 2 cycles
- fade_busy_o  out  1  high while in FADING_OUT or FADING_IN
- fade_done_o  out  1  one-cycle pulse when a fade completes

Behaviour:
- Reset values: all colour outputs 0, pixel_valid_o 0, fade_done_o 0, fade_busy_o 0. FSM goes to VISIBLE with level = MAX.
- Stage 1 (registered):
  - Select the lowest-index k where layer_enable_i[k]=1 and layer_color != KEY_COLOR.
  - If no such k, select BG_COLOR.
  - Register display_enable_i alongside the selected colour.
- Stage 2 (registered):
  - Each channel is computed as (c * level) >> FADE_LOG2.
  - The product is CW+FADE_LOG2+1 bits wide, so there is no overflow. level = MAX reproduces c exactly; level = 0 gives 0.
  - If the stage-1 display_enable is 0, the output is 0 regardless of layers.
  - pixel_valid_o is the 2-cycle delayed display_enable_i.
- Latency from input to outputs is 2 cycles. Full throughput, no stalls.
- level is a FADE_LOG2+1 bit register. Stage 2 uses its current value, so a level change affects pixels from the next cycle on. Because level only steps on frame_tick_i, changes land on frame boundaries.
- FSM states: VISIBLE, FADING_OUT, BLACK, FADING_IN.
  - VISIBLE + fade_out_req_i -> FADING_OUT.
  - FADING_OUT: on each frame_tick_i, level -= 1. When level becomes 0, go to BLACK in the same cycle and pulse fade_done_o on the following cycle.
  - BLACK + fade_in_req_i -> FADING_IN.
  - FADING_IN: on each frame_tick_i, level += 1. When level becomes MAX, go to VISIBLE and pulse fade_done_o on the following cycle.
  - fade_in_req_i in FADING_OUT: switch immediately to FADING_IN, keep the current level, no fade_done_o. The symmetric rule applies to fade_out_req_i in FADING_IN.
  - Requests that already match the current state or direction are ignored: fade_out_req_i in BLACK/FADING_OUT, fade_in_req_i in VISIBLE/FADING_IN.
  - fade_out_req_i and fade_in_req_i asserted together: ignored, no state change.
  - Request and frame_tick_i in the same cycle: the state transition is taken, the level is not stepped that cycle, and the first step happens on the next tick.
  - A full fade therefore takes exactly MAX ticks after the request cycle.
- fade_busy_o is a registered decode of FADING_OUT/FADING_IN. It is visible the cycle after the transition.
- Reset during a fade: rst_i wins over everything. The FSM returns to VISIBLE with level = MAX, the pipeline and outputs clear to 0, and no fade_done_o is produced.
- level never underflows below 0 or overflows above MAX. Ticks in VISIBLE or BLACK leave the level unchanged.

Test Plan:
- Priority: layer0 enabled with 0x000000 (key), layer1 = 0x102030, layer3 = 0xFFFFFF, all enabled, display on -> {b,g,r} = 0x102030 two cycles later, pixel_valid_o = 1.
- Background: layer_enable_i = 0, display on -> 0xE0E0E0 after 2 cycles. display_enable_i = 0 with layer0 = 0xFFFFFF -> output 0, pixel_valid_o = 0.
- Fade out: pulse fade_out_req_i, then 16 frame ticks.
  - After 8 ticks (level 8), input 0x804020 -> output 0x402010.
  - After tick 16: state BLACK, fade_done_o high for exactly 1 cycle, output 0x000000, fade_busy_o falls.
- Reversal: fade out for 5 ticks (level 11), then fade_in_req_i -> fade_busy_o stays 1 and no fade_done_o.
  - After 5 more ticks, level = 16 and fade_done_o pulses once.
  - Output equals the input colour exactly.
- Edge cases:
  - fade_out_req_i and fade_in_req_i together in VISIBLE -> no change.
  - fade_out_req_i coincident with frame_tick_i -> level is still 16 that cycle; BLACK is reached after 16 further ticks.
- Reset mid-fade: at level 6 in FADING_OUT, assert rst_i for 1 cycle.
  - Outputs 0, fade_busy_o = 0, no fade_done_o.
  - Afterwards, colour 0x804020 passes through unfaded with 2-cycle latency.
